trax_move_parser: RTL and testbench

//  Converts the ASCII move text delivered byte-by-byte by the UART receiver
//  (e.g. "AA128+\n") into the packed 22-bit move word used by the tranceiver
//  and game logic. Sits directly downstream of the UART rx path and upstream
//  of the move_in consumer. Flags malformed text and resynchronises on '\n'.

---
 rtl/trax_move_parser.sv | 157 +++++++++++++++
 tb/tb_trax_move_parser.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trax_move_parser.sv
// Turns a UART byte stream of Trax move text (e.g. AA128+ then newline) into a packed
// {col, row, tile} word. Optional macro: TRAX_PARSER_LOWERCASE_EN accepts a..z.
//
// state       | meaning
// S_IDLE      | waiting for the first column letter of a line
// S_COL       | collecting column letters
// S_ROW       | collecting row digits
// S_TILE_DONE | tile symbol seen, waiting for newline
// S_ERR       | malformed line, discarding bytes until newline
module trax_move_parser #(
  parameter int MAX_COL_CHARS  = 2,
  parameter int MAX_ROW_DIGITS = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [21:0] move_out,
  output logic        move_valid,
  output logic        parse_error,
  output logic        busy
);

  localparam int CW = $clog2(MAX_COL_CHARS + 1);
  localparam int DW = $clog2(MAX_ROW_DIGITS + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(MAX_COL_CHARS);
  localparam logic [DW-1:0] ROW_MAX = DW'(MAX_ROW_DIGITS);

  typedef enum logic [2:0] {S_IDLE, S_COL, S_ROW, S_TILE_DONE, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [9:0]    col_q, col_d;
  logic [9:0]    row_q, row_d;
  logic [1:0]    tile_q, tile_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [21:0]   move_q, move_d;
  logic          move_valid_q, move_valid_d;
  logic          parse_error_q, parse_error_d;
  logic          busy_q, busy_d;

  logic       is_upper, is_letter, is_digit, is_nz_digit, is_nl, is_cr, is_tile;
  logic [4:0] letter_val;
  logic [3:0] digit;
  logic [1:0] tile_code;

  // A..Z and a..z both carry their 1-based letter index in the low five bits
  assign is_upper    = (rx_data >= 8'h41) && (rx_data <= 8'h5A);
`ifdef TRAX_PARSER_LOWERCASE_EN
  assign is_letter   = is_upper || ((rx_data >= 8'h61) && (rx_data <= 8'h7A));
`else
  assign is_letter   = is_upper;
`endif
  assign letter_val  = rx_data[4:0];
  assign digit       = rx_data[3:0];
  assign is_digit    = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_nz_digit = is_digit && (rx_data != 8'h30);
  assign is_nl       = (rx_data == 8'h0A);
  assign is_cr       = (rx_data == 8'h0D);
  assign is_tile     = (rx_data == 8'h2B) || (rx_data == 8'h2F) || (rx_data == 8'h5C);
  assign tile_code   = (rx_data == 8'h2F) ? 2'b01 : (rx_data == 8'h5C) ? 2'b10 : 2'b00;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    tile_d       = tile_q;
    ccnt_d       = ccnt_q;
    dcnt_d       = dcnt_q;
    move_d       = move_q;
    move_valid_d = 1'b0;
    if (rx_valid && !is_cr) begin
      case (state_q)
        S_IDLE: begin
          if (is_letter) begin
            col_d   = {5'd0, letter_val};
            ccnt_d  = CW'(1);
            state_d = S_COL;
          end else if (!is_nl) begin
            state_d = S_ERR;
          end
        end
        S_COL: begin
          if (is_letter && (ccnt_q < COL_MAX)) begin
            col_d  = col_q * 10'd26 + {5'd0, letter_val};
            ccnt_d = ccnt_q + CW'(1);
          end else if (is_nz_digit) begin
            row_d   = {6'd0, digit};
            dcnt_d  = DW'(1);
            state_d = S_ROW;
          end else begin
            state_d = S_ERR;
          end
        end
        S_ROW: begin
          if (is_digit && (dcnt_q < ROW_MAX)) begin
            row_d  = row_q * 10'd10 + {6'd0, digit};
            dcnt_d = dcnt_q + DW'(1);
          end else if (is_tile) begin
            tile_d  = tile_code;
            state_d = S_TILE_DONE;
          end else begin
            state_d = S_ERR;
          end
        end
        S_TILE_DONE: begin
          if (is_nl) begin
            move_d       = {col_q, row_q, tile_q};
            move_valid_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d = S_ERR;
          end
        end
        S_ERR: begin
          if (is_nl) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    // only the entry into S_ERR flags, later junk on the same line stays quiet
    parse_error_d = (state_d == S_ERR) && (state_q != S_ERR);
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      col_q         <= '0;
      row_q         <= '0;
      tile_q        <= '0;
      ccnt_q        <= '0;
      dcnt_q        <= '0;
      move_q        <= '0;
      move_valid_q  <= 1'b0;
      parse_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      tile_q        <= tile_d;
      ccnt_q        <= ccnt_d;
      dcnt_q        <= dcnt_d;
      move_q        <= move_d;
      move_valid_q  <= move_valid_d;
      parse_error_q <= parse_error_d;
      busy_q        <= busy_d;
    end
  end

  assign move_out    = move_q;
  assign move_valid  = move_valid_q;
  assign parse_error = parse_error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_trax_move_parser.sv
// Bench for trax_move_parser: directed move lines followed by random lines,
// checked against a line-grammar reference model.
module tb_trax_move_parser;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [21:0] move_out;
  logic        move_valid, parse_error, busy;

  localparam logic [7:0] NL = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] BS = 8'h5C;

  int checks = 0;
  int failures = 0;

  logic        exp_mv = 1'b0, exp_pe = 1'b0, exp_busy = 1'b0;
  logic [21:0] exp_move = '0;
  logic [7:0]  lq[$];
  bit          disc = 1'b0;
  logic [7:0]  bq[$];

  trax_move_parser dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .move_out(move_out), .move_valid(move_valid), .parse_error(parse_error), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic bit is_let(logic [7:0] b);
`ifdef TRAX_PARSER_LOWERCASE_EN
    return (b >= "A" && b <= "Z") || (b >= "a" && b <= "z");
`else
    return (b >= "A" && b <= "Z");
`endif
  endfunction

  function automatic int let_val(logic [7:0] b);
    if (b >= "a") return int'(b) - int'("a") + 1;
    return int'(b) - int'("A") + 1;
  endfunction

  function automatic bit is_tile(logic [7:0] b);
    return (b == "+") || (b == "/") || (b == BS);
  endfunction

  // Is the text received so far on this line still the start of a legal move?
  function automatic bit prefix_ok();
    int n = lq.size();
    int i = 0;
    int nl = 0;
    int nd = 0;
    while (i < n && nl < 2 && is_let(lq[i])) begin i++; nl++; end
    if (nl == 0) return 1'b0;
    if (i == n) return 1'b1;
    if (!(lq[i] >= "1" && lq[i] <= "9")) return 1'b0;
    i++; nd = 1;
    while (i < n && nd < 3 && lq[i] >= "0" && lq[i] <= "9") begin i++; nd++; end
    if (i == n) return 1'b1;
    if (!is_tile(lq[i])) return 1'b0;
    return (i + 1 == n);
  endfunction

  function automatic logic [21:0] encode();
    int col = 0;
    int row = 0;
    int i = 0;
    logic [1:0] t;
    logic [9:0] c10, r10;
    while (is_let(lq[i])) begin col = col * 26 + let_val(lq[i]); i++; end
    while (lq[i] >= "0" && lq[i] <= "9") begin row = row * 10 + int'(lq[i] - "0"); i++; end
    t = (lq[i] == "/") ? 2'b01 : (lq[i] == BS) ? 2'b10 : 2'b00;
    c10 = col[9:0];
    r10 = row[9:0];
    return {c10, r10, t};
  endfunction

  task automatic model_byte(input logic [7:0] b);
    exp_mv = 1'b0;
    exp_pe = 1'b0;
    if (b == CR) begin
    end else if (disc) begin
      if (b == NL) disc = 1'b0;
    end else if (b == NL) begin
      if (lq.size() != 0) begin
        if (prefix_ok() && is_tile(lq[lq.size()-1])) begin
          exp_move = encode();
          exp_mv   = 1'b1;
        end else begin
          exp_pe = 1'b1;
          disc   = 1'b1;
        end
        lq.delete();
      end
    end else begin
      lq.push_back(b);
      if (!prefix_ok()) begin
        exp_pe = 1'b1;
        disc   = 1'b1;
        lq.delete();
      end
    end
    exp_busy = disc || (lq.size() != 0);
  endtask

  task automatic check_outputs(input string tag);
    checks++;
    assert (move_valid === exp_mv) else begin
      failures++; $error("FAIL %s move_valid got=%0b exp=%0b", tag, move_valid, exp_mv);
    end
    checks++;
    assert (parse_error === exp_pe) else begin
      failures++; $error("FAIL %s parse_error got=%0b exp=%0b", tag, parse_error, exp_pe);
    end
    checks++;
    assert (busy === exp_busy) else begin
      failures++; $error("FAIL %s busy got=%0b exp=%0b", tag, busy, exp_busy);
    end
    checks++;
    assert (move_out === exp_move) else begin
      failures++; $error("FAIL %s move_out got=%h exp=%h", tag, move_out, exp_move);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = v ? d : 8'($urandom);
    if (v) model_byte(d);
    else begin exp_mv = 1'b0; exp_pe = 1'b0; end
    @(negedge clock);
    check_outputs("step");
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    step(1'b1, b);
    if (gaps) repeat ($urandom_range(1, 3)) step(1'b0, 8'h00);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i]);
      if (gaps) repeat ($urandom_range(1, 3)) step(1'b0, 8'h00);
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_bq(input bit gaps);
    for (int i = 0; i < bq.size(); i++) begin
      step(1'b1, bq[i]);
      if (gaps) repeat ($urandom_range(0, 2)) step(1'b0, 8'h00);
    end
    rx_valid = 1'b0;
  endtask

  task automatic expect_move(input string tag, input logic [21:0] v);
    checks++;
    assert (move_out === v) else begin
      failures++; $error("FAIL %s move_out got=%h exp=%h", tag, move_out, v);
    end
  endtask

  task automatic push_letter(input int idx, input bit lower);
    logic [7:0] c;
    c = 8'("A" + idx - 1);
    if (lower) c = c + 8'h20;
    bq.push_back(c);
  endtask

  function automatic logic [7:0] pool_pick(input string ps, input int idx);
    if (idx < ps.len()) return ps[idx];
    if (idx == ps.len()) return NL;
    return CR;
  endfunction

  initial begin
    string pool;
    logic [7:0] tiles [3];
    int row, ncol;
    bit lower;
    pool = "A0Z9+/@a x";
    tiles[0] = "+"; tiles[1] = "/"; tiles[2] = BS;

    repeat (3) @(negedge clock);
    check_outputs("reset");
    reset = 1'b1;
    @(negedge clock);

    send_str("AA128+", 1'b0);
    send_byte(NL, 1'b0);
    step(1'b0, 8'h00);
    expect_move("aa128", 22'h01B200);

    send_str("B3/", 1'b1);
    send_byte(CR, 1'b1);
    send_byte(NL, 1'b1);
    expect_move("b3", 22'h00200D);

    send_str("@0+", 1'b0);
    send_byte(NL, 1'b0);
    expect_move("err_keep", 22'h00200D);
    send_str("A1", 1'b0);
    send_byte(BS, 1'b0);
    send_byte(NL, 1'b0);
    expect_move("a1", 22'h001006);

    send_str("A1234+", 1'b0);
    send_byte(NL, 1'b0);
    send_str("ZZ999+", 1'b0);
    send_byte(NL, 1'b0);
    expect_move("zz999", {10'd702, 10'd999, 2'b00});

    send_str("AB12", 1'b0);
    reset = 1'b0;
    #1;
    lq.delete(); disc = 1'b0;
    exp_move = '0; exp_mv = 1'b0; exp_pe = 1'b0; exp_busy = 1'b0;
    check_outputs("mid_reset");
    @(negedge clock);
    reset = 1'b1;
    send_str("C7+", 1'b0);
    send_byte(NL, 1'b0);
    expect_move("c7", {10'd3, 10'd7, 2'b00});

    send_str("a5+", 1'b0);
    send_byte(NL, 1'b0);
    step(1'b0, 8'h00);
`ifdef TRAX_PARSER_LOWERCASE_EN
    expect_move("lower", {10'd1, 10'd5, 2'b00});
`else
    expect_move("lower", {10'd3, 10'd7, 2'b00});
`endif

    send_byte(NL, 1'b0);
    send_byte(NL, 1'b0);
    send_str("Q10/", 1'b0);
    send_byte(NL, 1'b0);

    for (int n = 0; n < 250; n++) begin
      bq.delete();
      if ($urandom_range(0, 9) == 0) begin
        bq.push_back(NL);
      end else begin
        lower = ($urandom_range(0, 5) == 0);
        ncol  = $urandom_range(1, 2);
        for (int k = 0; k < ncol; k++) push_letter($urandom_range(1, 26), lower);
        row = $urandom_range(1, 999);
        if (row >= 100) bq.push_back(8'("0" + row / 100));
        if (row >= 10) bq.push_back(8'("0" + (row / 10) % 10));
        bq.push_back(8'("0" + row % 10));
        bq.push_back(tiles[$urandom_range(0, 2)]);
        if ($urandom_range(0, 3) == 0) bq.push_back(CR);
        bq.push_back(NL);
        if ($urandom_range(0, 3) == 0)
          bq[$urandom_range(0, bq.size() - 1)] = pool_pick(pool, $urandom_range(0, pool.len() + 1));
        if ($urandom_range(0, 9) == 0) bq.insert(1, "7");
      end
      send_bq($urandom_range(0, 1) == 1);
    end
    send_byte(NL, 1'b0);
    send_str("D4+", 1'b0);
    send_byte(NL, 1'b0);
    step(1'b0, 8'h00);
    expect_move("final", {10'd4, 10'd4, 2'b00});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
